// File: rtl/mem_ctrl.sv
// mem_ctrl -- single-port memory access controller sitting between the CPU
// control unit and a word-organised memory.
//
// A request is accepted in IDLE, checked for alignment and range, then either
// answered immediately with an error or carried out against the memory:
// loads hold the read strobe for READ_LAT cycles and capture the returned
// word into ir (instruction fetch) or mdr (data load); stores pulse the
// write strobe for one cycle. Every request ends with a one-cycle response.
//
// Parameters:
//   MEM_WORDS  number of addressable 32-bit words in the attached memory
//   READ_LAT   cycles the read strobe is held before data is captured (1-4)
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   req_valid/ready   request handshake from/to the CPU control unit
//   req_write         1 = store, 0 = load
//   req_fetch         load destination: 1 = ir, 0 = mdr
//   req_addr          byte address of the access
//   req_wdata         store data
//   resp_valid/err    one-cycle completion pulse and its error qualifier
//   ir, mdr           instruction and memory data registers
//   mem_address       word address presented to memory
//   mem_writeData     store data presented to memory
//   mem_memwrite      memory write strobe
//   mem_memread       memory read strobe
//   mem_rdata         read data returned by memory

module mem_ctrl #(
  parameter int MEM_WORDS = 50,
  parameter int READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_fetch,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Index of the final read-strobe cycle; the capture happens at the edge
  // that ends it.
  localparam logic [2:0] LAST_READ_CYCLE = 3'(READ_LAT - 1);

  state_t     state;
  logic       is_write;
  logic       is_fetch;
  logic [2:0] lat_cnt;
  logic       addr_err;

  // Misaligned byte addresses and word indices past the end of the memory
  // are refused before any strobe is raised.
  assign addr_err = (req_addr[1:0] != 2'b00) ||
                    ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

  // Ready is gated by rst_n so it reads 0 throughout reset even though the
  // state register already sits in IDLE.
  assign req_ready = rst_n && (state == IDLE);

  // Controller FSM. All memory-side and response outputs are registered here
  // so the async reset clears strobes the instant rst_n falls, which also
  // discards any access in flight without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      is_write      <= 1'b0;
      is_fetch      <= 1'b0;
      lat_cnt       <= 3'd0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      ir            <= 32'd0;
      mdr           <= 32'd0;
      mem_address   <= 6'd0;
      mem_writeData <= 32'd0;
      mem_memwrite  <= 1'b0;
      mem_memread   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          if (req_valid) begin
            // Everything about the request is latched here; the req_* inputs
            // are not looked at again until the controller is back in IDLE.
            is_write      <= req_write;
            is_fetch      <= req_fetch;
            mem_writeData <= req_wdata;
            lat_cnt       <= 3'd0;
            if (addr_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state        <= ACCESS;
              mem_address  <= req_addr[7:2];
              mem_memwrite <= req_write;
              mem_memread  <= !req_write;
            end
          end
        end

        ACCESS: begin
          if (is_write) begin
            mem_memwrite <= 1'b0;
            state        <= RESP;
            resp_valid   <= 1'b1;
            resp_err     <= 1'b0;
          end else if (lat_cnt == LAST_READ_CYCLE) begin
            mem_memread <= 1'b0;
            if (is_fetch) begin
              ir <= mem_rdata;
            end else begin
              mdr <= mem_rdata;
            end
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end

        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state        <= IDLE;
          resp_valid   <= 1'b0;
          resp_err     <= 1'b0;
          mem_memwrite <= 1'b0;
          mem_memread  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl -- self-checking bench for mem_ctrl.
//
// Two controllers share one behavioural memory: one built with READ_LAT=1 and
// one with READ_LAT=3. 'sel' picks which one receives requests and whose
// outputs are observed; the other sits idle. Expected responses are pushed to
// a queue when a request is driven and popped when the response appears.

module tb_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic        req_fetch;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_rdata;
  logic        mem_load;

  logic        r1_ready, r1_rvalid, r1_rerr, r1_wr, r1_rd;
  logic [31:0] r1_ir, r1_mdr, r1_wdata;
  logic [5:0]  r1_addr;
  logic        r3_ready, r3_rvalid, r3_rerr, r3_wr, r3_rd;
  logic [31:0] r3_ir, r3_mdr, r3_wdata;
  logic [5:0]  r3_addr;

  logic        req_ready, resp_valid, resp_err, mem_memwrite, mem_memread;
  logic [31:0] ir, mdr, mem_writeData;
  logic [5:0]  mem_address;

  mem_ctrl #(.MEM_WORDS(50), .READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && !sel), .req_ready(r1_ready),
    .req_write(req_write), .req_fetch(req_fetch),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(r1_rvalid), .resp_err(r1_rerr),
    .ir(r1_ir), .mdr(r1_mdr),
    .mem_address(r1_addr), .mem_writeData(r1_wdata),
    .mem_memwrite(r1_wr), .mem_memread(r1_rd),
    .mem_rdata(mem_rdata)
  );

  mem_ctrl #(.MEM_WORDS(50), .READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel), .req_ready(r3_ready),
    .req_write(req_write), .req_fetch(req_fetch),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(r3_rvalid), .resp_err(r3_rerr),
    .ir(r3_ir), .mdr(r3_mdr),
    .mem_address(r3_addr), .mem_writeData(r3_wdata),
    .mem_memwrite(r3_wr), .mem_memread(r3_rd),
    .mem_rdata(mem_rdata)
  );

  // Route the selected controller onto the observed signal set.
  always_comb begin
    if (sel) begin
      req_ready = r3_ready;  resp_valid = r3_rvalid; resp_err = r3_rerr;
      ir = r3_ir;            mdr = r3_mdr;           mem_address = r3_addr;
      mem_writeData = r3_wdata; mem_memwrite = r3_wr; mem_memread = r3_rd;
    end else begin
      req_ready = r1_ready;  resp_valid = r1_rvalid; resp_err = r1_rerr;
      ir = r1_ir;            mdr = r1_mdr;           mem_address = r1_addr;
      mem_writeData = r1_wdata; mem_memwrite = r1_wr; mem_memread = r1_rd;
    end
  end

  function automatic logic [31:0] initWord(input int i);
    if (i == 0) return 32'h00430822;
    return 32'hA5000000 + 32'(i) * 32'h00000101;
  endfunction

  // Behavioural memory: combinational read, write on the rising edge.
  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_address];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= initWord(i);
    end else if (mem_memwrite) begin
      mem[mem_address] <= mem_writeData;
    end
  end

  typedef struct {
    logic        err;
    int          lat;
    logic [31:0] ir_v;
    logic [31:0] mdr_v;
    int          rd;
    int          wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl_mem [0:63];
  logic [31:0] mdl_ir;
  logic [31:0] mdl_mdr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Fill the req_* inputs with values that must not be picked up; a
  // misaligned address makes any wrongful acceptance show up as an error.
  task automatic scramble(input logic wr, input logic fetch);
    req_addr  = $urandom | 32'h1;
    req_wdata = $urandom;
    req_write = !wr;
    req_fetch = !fetch;
  endtask

  // Drive one request starting at a falling edge, then follow it to its
  // response. With hold=1, req_valid stays high and the request fields keep
  // changing while the controller is busy. Returns at the falling edge of
  // the first IDLE cycle after the response.
  task automatic applyStimulus(input logic wr, input logic fetch,
                               input logic [31:0] addr,
                               input logic [31:0] wdata, input logic hold);
    exp_t e;
    exp_t got_e;
    int   n;
    int   waitc;
    int   rd_cnt;
    int   wr_cnt;
    int   bad;
    int   cur_lat;

    cur_lat = sel ? 3 : 1;
    e.err   = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd50);
    e.addr  = addr[7:2];
    e.wdata = wdata;
    if (e.err) begin
      e.lat = 1; e.rd = 0; e.wr = 0;
    end else if (wr) begin
      e.lat = 2; e.rd = 0; e.wr = 1;
      mdl_mem[addr[7:2]] = wdata;
    end else begin
      e.lat = cur_lat + 1; e.rd = cur_lat; e.wr = 0;
      if (fetch) mdl_ir = mdl_mem[addr[7:2]];
      else       mdl_mdr = mdl_mem[addr[7:2]];
    end
    e.ir_v  = mdl_ir;
    e.mdr_v = mdl_mdr;
    exp_q.push_back(e);

    req_valid = 1'b1;
    req_write = wr;
    req_fetch = fetch;
    req_addr  = addr;
    req_wdata = wdata;

    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", {31'd0, req_ready}, 32'd1);
      void'(exp_q.pop_back());
      req_valid = 1'b0;
      return;
    end

    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    scramble(wr, fetch);
    @(negedge clk);
    n = 1; rd_cnt = 0; wr_cnt = 0; bad = 0;

    while (!resp_valid && n < 16) begin
      if (mem_memread) rd_cnt++;
      if (mem_memwrite) wr_cnt++;
      if ((mem_memread || mem_memwrite) && mem_address != e.addr) bad++;
      if (mem_memread && mem_memwrite) bad++;
      if (mem_memwrite && mem_writeData != e.wdata) bad++;
      if (resp_err || req_ready) bad++;
      @(posedge clk);
      #1;
      if (hold) scramble(wr, fetch);
      @(negedge clk);
      n++;
    end

    got_e = exp_q.pop_front();
    checkOutput("resp_valid", {31'd0, resp_valid}, 32'd1);
    checkOutput("latency", n, got_e.lat);
    checkOutput("resp_err", {31'd0, resp_err}, {31'd0, got_e.err});
    checkOutput("ir", ir, got_e.ir_v);
    checkOutput("mdr", mdr, got_e.mdr_v);
    checkOutput("read_cycles", rd_cnt, got_e.rd);
    checkOutput("write_cycles", wr_cnt, got_e.wr);
    checkOutput("strobes_in_resp", {30'd0, mem_memread, mem_memwrite}, 32'd0);
    checkOutput("ready_in_resp", {31'd0, req_ready}, 32'd0);
    checkOutput("access_protocol", bad, 0);

    @(posedge clk);
    #1;
    checkOutput("resp_one_cycle", {30'd0, resp_valid, resp_err}, 32'd0);
    checkOutput("ready_after_resp", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rst_bad;

    rst_n     = 1'b0;
    sel       = 1'b0;
    mem_load  = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_fetch = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) mdl_mem[i] = initWord(i);
    mdl_ir  = 32'd0;
    mdl_mdr = 32'd0;

    @(posedge clk);
    @(posedge clk);
    #1;
    mem_load = 1'b0;

    // Reset values while rst_n is held low.
    checkOutput("rst_ir", ir, 32'd0);
    checkOutput("rst_mdr", mdr, 32'd0);
    checkOutput("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    checkOutput("rst_strobes", {30'd0, mem_memread, mem_memwrite}, 32'd0);
    checkOutput("rst_mem_address", {26'd0, mem_address}, 32'd0);
    checkOutput("rst_mem_writeData", mem_writeData, 32'd0);
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_release", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    // READ_LAT=1 controller.
    applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'd0, 1'b0);        // fetch word 0
    applyStimulus(1'b1, 1'b0, 32'h0000_0014, 32'hDEADBEEF, 1'b0); // store word 5
    applyStimulus(1'b0, 1'b0, 32'h0000_0014, 32'd0, 1'b0);        // load it back
    applyStimulus(1'b0, 1'b0, 32'h0000_0006, 32'd0, 1'b0);        // misaligned
    applyStimulus(1'b0, 1'b1, 32'h0000_00C8, 32'd0, 1'b0);        // word 50
    applyStimulus(1'b1, 1'b0, 32'h0000_00C8, 32'h11111111, 1'b0); // store past end
    applyStimulus(1'b0, 1'b0, 32'h0000_00C4, 32'd0, 1'b0);        // last word
    applyStimulus(1'b0, 1'b0, 32'h0100_0000, 32'd0, 1'b0);        // high bits set

    // Back-to-back with req_valid held high and fields churning while busy.
    applyStimulus(1'b0, 1'b1, 32'h0000_0008, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0000_0010, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'hCAFEF00D, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0000_0020, 32'd0, 1'b1);
    req_valid = 1'b0;

    // READ_LAT=3 controller; its ir/mdr start from zero.
    sel     = 1'b1;
    mdl_ir  = 32'd0;
    mdl_mdr = 32'd0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0000_0008, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0014, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0030, 32'h0BADC0DE, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0030, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0002, 32'd0, 1'b0);

    // Reset during the ACCESS cycle of a store on the READ_LAT=1 controller.
    sel     = 1'b0;
    mdl_ir  = 32'h00430822;
    mdl_mdr = mdl_mem[8];
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_fetch = 1'b0;
    req_addr  = 32'h0000_0018;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("midrst_write_strobe", {31'd0, mem_memwrite}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_strobes_drop", {30'd0, mem_memread, mem_memwrite}, 32'd0);
    checkOutput("midrst_ir", ir, 32'd0);
    checkOutput("midrst_mdr", mdr, 32'd0);
    checkOutput("midrst_ready", {31'd0, req_ready}, 32'd0);
    rst_bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid || resp_err || mem_memwrite) rst_bad++;
    end
    checkOutput("midrst_no_response", rst_bad, 0);
    rst_n   = 1'b1;
    mdl_ir  = 32'd0;
    mdl_mdr = 32'd0;
    @(posedge clk);
    #1;
    checkOutput("midrst_ready_after", {31'd0, req_ready}, 32'd1);
    checkOutput("midrst_no_late_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);

    // The interrupted store must not have reached memory.
    applyStimulus(1'b0, 1'b0, 32'h0000_0018, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0014, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter MEM_WORDS, default 50: number of addressable 32-bit words in the attached memory.
REQ-002 Parameter READ_LAT, default 1, range 1-4: cycles memread is held before read data is captured.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  CPU control requests a memory access.
REQ-006 req_ready  out  1  controller can accept a request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_fetch  in  1  for loads: 1 = capture into ir, 0 = capture into mdr; ignored for stores.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_err  out  1  qualifies resp_valid; access rejected.
REQ-013 ir  out  32  instruction register.
REQ-014 mdr  out  32  memory data register.
REQ-015 mem_address  out  6  word address to memory.
REQ-016 mem_writeData  out  32  store data to memory.
REQ-017 mem_memwrite  out  1  memory write enable.
REQ-018 mem_memread  out  1  memory read enable.
REQ-019 mem_rdata  in  32  memory read data (out32 of memory).

Function
REQ-020 States SHALL be IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE with rst_n high.
REQ-021 Acceptance SHALL occur on a rising edge with req_valid=1 in IDLE. The controller SHALL latch req_write, req_fetch, req_addr and req_wdata at that edge, and later changes on the req_* inputs SHALL be ignored.
REQ-022 Error check at acceptance: req_addr[1:0]!=0, or word index req_addr[31:2] >= MEM_WORDS, SHALL mark the request as an error.
REQ-023 Error request: IDLE->RESP directly with no memory strobe; ir and mdr SHALL be unchanged.
REQ-024 Valid request: IDLE->ACCESS; mem_address SHALL equal latched req_addr[7:2] for the whole ACCESS period.
REQ-025 Load: mem_memread=1 for exactly READ_LAT ACCESS cycles. mem_rdata SHALL be captured into ir (fetch) or mdr (data) at the edge ending the last cycle, followed by ACCESS->RESP.
REQ-026 Store: mem_memwrite=1 for exactly one ACCESS cycle with mem_writeData = latched req_wdata, followed by ACCESS->RESP.
REQ-027 mem_memread and mem_memwrite SHALL never be 1 simultaneously, and both SHALL be 0 outside ACCESS.
REQ-028 RESP SHALL last one cycle with resp_valid=1 and resp_err equal to the error flag, followed by RESP->IDLE.
REQ-029 resp_err SHALL be 0 whenever resp_valid is 0.
REQ-030 Latency from acceptance edge to resp_valid high: load READ_LAT+1 cycles, store 2 cycles, error 1 cycle.
REQ-031 A new request SHALL NOT be accepted in the RESP cycle, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-032 ir and mdr SHALL change only on a successful load capture.

Reset
REQ-033 While rst_n=0: state IDLE, ir=0, mdr=0, resp_valid=0, resp_err=0, mem_memread=0, mem_memwrite=0, mem_address=0, mem_writeData=0, req_ready=0.
REQ-034 Reset asserted mid-ACCESS or mid-RESP SHALL drop strobes immediately (asynchronously), discard the request and produce no response.
REQ-035 req_ready SHALL rise to 1 in the first cycle after rst_n deasserts.

Verification
REQ-036 Fetch: READ_LAT=1, memory word 0 = 0x00430822, request addr 0x0 with fetch=1 -> memread high 1 cycle at mem_address 0; resp_valid 2 cycles after acceptance; ir=0x00430822; mdr unchanged.
REQ-037 Store then load: store 0xDEADBEEF to 0x14 -> memwrite 1 cycle at mem_address 5; then a data load from 0x14 -> mdr=0xDEADBEEF, resp_err=0.
REQ-038 Errors: request addr 0x6 (misaligned) and addr 0xC8 (word 50) -> resp_valid with resp_err=1 one cycle after acceptance; no strobes; ir and mdr unchanged.
REQ-039 READ_LAT=3: load from 0x8 -> memread high 3 consecutive cycles; resp_valid 4 cycles after acceptance.
REQ-040 Reset mid-store: drop rst_n during the ACCESS cycle of a store -> memwrite falls immediately, no resp_valid, ir=mdr=0; req_ready=1 one cycle after release.
REQ-041 Handshake: hold req_valid=1 continuously with changing req_addr -> only values present at IDLE edges are accepted; req_ready=0 during ACCESS and RESP.
